// File: rtl/layer2_out_skid_stage.sv
// rtl/layer2_out_skid_stage.sv - elastic 2-entry skid stage between layer-2 and layer-3 LUT arrays
//
// Registers the packed layer-2 neuron output vector behind a valid/ready
// handshake. A main register drives the downstream port. A skid register
// catches the one sample that can arrive while main is stalled. s_ready is a
// flop output, so the upstream ready does not depend combinationally on m_ready.
// Each accepted sample is tagged with a wrapping sequence number.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    upstream sample valid
//   s_ready    stage can accept (registered, = !skid valid)
//   s_data     layer-2 neuron output vector, bit i = neuron i
//   m_valid    main register holds a sample
//   m_ready    layer-3 stage accepts
//   m_data     sample presented downstream
//   m_tag      sequence tag of the sample on m_data
//   occupancy  entries held: 0, 1 or 2
module layer2_out_skid_stage #(
  parameter int WIDTH = 512,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic [TAG_W-1:0] tag_cnt_q,    tag_cnt_d;

  logic in_fire;
  logic out_fire;

  // s_ready is exactly the inverse of the skid flop, so it stays registered.
  assign s_ready  = ~skid_valid_q;
  assign in_fire  = s_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & m_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    tag_cnt_d    = tag_cnt_q;

    if (in_fire) begin
      tag_cnt_d = tag_cnt_q + 1'b1;
    end

    if (skid_valid_q) begin
      // Skid full implies s_ready=0, so no input can arrive here; only drain.
      if (out_fire) begin
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = s_data;
        main_tag_d   = tag_cnt_q;
      end else begin
        // Main stalled: park the sample, s_ready drops next cycle.
        skid_valid_d = 1'b1;
        skid_data_d  = s_data;
        skid_tag_d   = tag_cnt_q;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      tag_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      tag_cnt_q    <= tag_cnt_d;
    end
  end

  assign m_valid   = main_valid_q;
  assign m_data    = main_data_q;
  assign m_tag     = main_tag_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_layer2_out_skid_stage.sv
// tb/tb_layer2_out_skid_stage.sv - self-checking bench for layer2_out_skid_stage
module tb_layer2_out_skid_stage;

  localparam int WIDTH = 512;
  localparam int TAG_W = 8;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic [1:0]       occupancy;

  int n_tests;
  int n_fail;

  layer2_out_skid_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_tag     (m_tag),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic       mr;
    logic [7:0] d;
    logic       e_sr;
    logic       e_mv;
    logic [7:0] e_d;
    logic [7:0] e_tag;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [WIDTH-1:0] rep(input logic [7:0] b);
    return {(WIDTH/8){b}};
  endfunction

  // Compares the full output state; data/tag are only meaningful while m_valid.
  task automatic check_state(input string name, input logic e_sr, input logic e_mv,
                             input logic [7:0] e_d, input logic [7:0] e_tag,
                             input logic [1:0] e_occ);
    logic ok;
    ok = (s_ready === e_sr) && (m_valid === e_mv) && (occupancy === e_occ);
    if (e_mv) ok = ok && (m_data === rep(e_d)) && (m_tag === e_tag);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got s_ready=%b m_valid=%b m_data[31:0]=%h m_tag=%0d occ=%0d, want s_ready=%b m_valid=%b data_byte=%h m_tag=%0d occ=%0d",
               name, s_ready, m_valid, m_data[31:0], m_tag, occupancy,
               e_sr, e_mv, e_d, e_tag, e_occ);
    end
  endtask

  task automatic step(input logic sv, input logic mr, input logic [7:0] d);
    @(negedge clk);
    s_valid = sv;
    m_ready = mr;
    s_data  = rep(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;

    //            sv    mr    d      sr    mv    e_d    tag   occ
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 8'd0, 2'd1};
    vecs[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'd1, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 8'hD0, 1'b1, 1'b1, 8'hD0, 8'd2, 2'd1};
    vecs[4]  = '{1'b1, 1'b0, 8'hD1, 1'b0, 1'b1, 8'hD0, 8'd2, 2'd2};
    vecs[5]  = '{1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 8'hD0, 8'd2, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hD1, 8'd3, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 8'd4, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 8'd4, 2'd2};
    vecs[10] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 8'd5, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 8'd6, 2'd1};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 2'd0};

    // Reset held: full reset state including zeroed data.
    repeat (2) @(negedge clk);
    n_tests++;
    if (m_data !== '0 || m_tag !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_hold: m_valid=%b s_ready=%b occ=%0d m_tag=%0d m_data[31:0]=%h, want 0/1/0/0/0",
               m_valid, s_ready, occupancy, m_tag, m_data[31:0]);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_reset_idle", 1'b1, 1'b0, 8'h00, 8'd0, 2'd0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].sv, vecs[i].mr, vecs[i].d);
      check_state($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_mv,
                  vecs[i].e_d, vecs[i].e_tag, vecs[i].e_occ);
    end

    // Fill to occupancy 2 (tags 7, 8), then assert reset between edges.
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    check_state("prefill_full", 1'b0, 1'b1, 8'h55, 8'd7, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_reset_immediate", 1'b1, 1'b0, 8'h00, 8'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;

    // Stream 257 samples at full rate; tags must run 0..255 then wrap to 0.
    for (int k = 0; k < 257; k++) begin
      step(1'b1, 1'b1, k[7:0] ^ 8'h5A);
      check_state($sformatf("wrap%0d", k), 1'b1, 1'b1, k[7:0] ^ 8'h5A, k[7:0], 2'd1);
    end
    step(1'b0, 1'b1, 8'h00);
    check_state("wrap_drain", 1'b1, 1'b0, 8'h00, 8'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
